// File: rtl/sdram_read_checker.sv
// rtl/sdram_read_checker.sv - in-order SDRAM read-response checker (optional SDRAM_READ_CHECKER_CAPTURE_EN first-error capture)
module sdram_read_checker #(
  parameter int AddrWidth     = 8,
  parameter int DataWidth     = 8,
  parameter int Depth         = 4,
  parameter int ErrCountWidth = 8
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       clr,
  input  logic                       issueValid,
  input  logic [AddrWidth-1:0]       issueAddr,
  output logic                       issueReady,
  input  logic                       rdValid,
  input  logic [DataWidth-1:0]       rdData,
  output logic [$clog2(Depth):0]     pending,
  output logic                       status,
  output logic [ErrCountWidth-1:0]   errCount,
  output logic                       errUnexpected,
`ifdef SDRAM_READ_CHECKER_CAPTURE_EN
  output logic                       firstErrValid,
  output logic [DataWidth-1:0]       firstErrExpected,
  output logic [DataWidth-1:0]       firstErrData,
`endif
  output logic                       errOverflow
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  // Expected-data storage; holds the test pattern, not the address.
  logic [DataWidth-1:0] mem_q [Depth];

  logic [PtrW-1:0]          wr_q, wr_d;
  logic [PtrW-1:0]          rd_q, rd_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     status_q, status_d;
  logic [ErrCountWidth-1:0] errcnt_q, errcnt_d;
  logic                     unexp_q, unexp_d;
  logic                     ovf_q, ovf_d;
`ifdef SDRAM_READ_CHECKER_CAPTURE_EN
  logic                     fev_q, fev_d;
  logic [DataWidth-1:0]     fexp_q, fexp_d;
  logic [DataWidth-1:0]     fdata_q, fdata_d;
`endif

  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push;
  logic                 unexpected;
  logic                 overflow;
  logic                 mismatch;
  logic [DataWidth-1:0] head;
  logic [DataWidth-1:0] push_exp;

  assign full       = (cnt_q == FullCnt);
  assign empty      = (cnt_q == '0);
  assign head       = mem_q[rd_q];
  assign push_exp   = ~issueAddr[DataWidth-1:0];
  assign pop        = rdValid && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push       = issueValid && (!full || pop);
  assign overflow   = issueValid && full && !pop;
  assign unexpected = rdValid && empty;
  assign mismatch   = pop && (rdData != head);

  assign issueReady    = !full;
  assign pending       = cnt_q;
  assign status        = status_q;
  assign errCount      = errcnt_q;
  assign errUnexpected = unexp_q;
  assign errOverflow   = ovf_q;
`ifdef SDRAM_READ_CHECKER_CAPTURE_EN
  assign firstErrValid    = fev_q;
  assign firstErrExpected = fexp_q;
  assign firstErrData     = fdata_q;
`endif

  // Next-state: clr wins over every same-cycle event, otherwise apply push/pop/error updates.
  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    errcnt_d = errcnt_q;
    unexp_d  = unexp_q;
    ovf_d    = ovf_q;
`ifdef SDRAM_READ_CHECKER_CAPTURE_EN
    fev_d    = fev_q;
    fexp_d   = fexp_q;
    fdata_d  = fdata_q;
`endif
    if (clr) begin
      wr_d     = '0;
      rd_d     = '0;
      cnt_d    = '0;
      status_d = 1'b1;
      errcnt_d = '0;
      unexp_d  = 1'b0;
      ovf_d    = 1'b0;
`ifdef SDRAM_READ_CHECKER_CAPTURE_EN
      fev_d    = 1'b0;
      fexp_d   = '0;
      fdata_d  = '0;
`endif
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      if (mismatch) begin
        status_d = 1'b0;
        if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
      end
      if (unexpected) begin
        status_d = 1'b0;
        unexp_d  = 1'b1;
      end
      if (overflow) begin
        status_d = 1'b0;
        ovf_d    = 1'b1;
      end
`ifdef SDRAM_READ_CHECKER_CAPTURE_EN
      // The three error kinds are mutually exclusive within one cycle.
      if (!fev_q) begin
        if (mismatch) begin
          fev_d   = 1'b1;
          fexp_d  = head;
          fdata_d = rdData;
        end else if (unexpected) begin
          fev_d   = 1'b1;
          fexp_d  = '0;
          fdata_d = rdData;
        end else if (overflow) begin
          fev_d   = 1'b1;
          fexp_d  = '0;
          fdata_d = issueAddr[DataWidth-1:0];
        end
      end
`endif
    end
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      status_q <= 1'b1;
      errcnt_q <= '0;
      unexp_q  <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SDRAM_READ_CHECKER_CAPTURE_EN
      fev_q    <= 1'b0;
      fexp_q   <= '0;
      fdata_q  <= '0;
`endif
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      errcnt_q <= errcnt_d;
      unexp_q  <= unexp_d;
      ovf_q    <= ovf_d;
`ifdef SDRAM_READ_CHECKER_CAPTURE_EN
      fev_q    <= fev_d;
      fexp_q   <= fexp_d;
      fdata_q  <= fdata_d;
`endif
    end
  end

  // Entry storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_q] <= push_exp;
  end

endmodule

// File: tb/tb_sdram_read_checker.sv
// tb/tb_sdram_read_checker.sv - self-checking bench for sdram_read_checker against a queue model
module tb_sdram_read_checker;

  logic       clk = 1'b0;
  logic       rst_;
  logic       clr;
  logic       issueValid;
  logic [7:0] issueAddr;
  logic       issueReady;
  logic       rdValid;
  logic [7:0] rdData;
  logic [2:0] pending;
  logic       status;
  logic [7:0] errCount;
  logic       errUnexpected;
  logic       errOverflow;
`ifdef SDRAM_READ_CHECKER_CAPTURE_EN
  logic       firstErrValid;
  logic [7:0] firstErrExpected;
  logic [7:0] firstErrData;
`endif

  sdram_read_checker dut (
    .clk(clk),
    .rst_(rst_),
    .clr(clr),
    .issueValid(issueValid),
    .issueAddr(issueAddr),
    .issueReady(issueReady),
    .rdValid(rdValid),
    .rdData(rdData),
    .pending(pending),
    .status(status),
    .errCount(errCount),
    .errUnexpected(errUnexpected),
`ifdef SDRAM_READ_CHECKER_CAPTURE_EN
    .firstErrValid(firstErrValid),
    .firstErrExpected(firstErrExpected),
    .firstErrData(firstErrData),
`endif
    .errOverflow(errOverflow)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: a queue of expected bytes plus sticky flags.
  logic [7:0] q[$];
  bit         m_status;
  int         m_err;
  bit         m_unexp;
  bit         m_ovf;
  bit         m_fev;
  logic [7:0] m_fexp;
  logic [7:0] m_fdata;

  task automatic model_reset();
    q.delete();
    m_status = 1; m_err = 0; m_unexp = 0; m_ovf = 0;
    m_fev = 0; m_fexp = 0; m_fdata = 0;
  endtask

  task automatic model_capture(input logic [7:0] e, input logic [7:0] d);
    if (!m_fev) begin
      m_fev = 1; m_fexp = e; m_fdata = d;
    end
  endtask

  task automatic model_step(input bit iv, input logic [7:0] ia, input bit rv,
                            input logic [7:0] rd, input bit c);
    logic [7:0] h;
    if (c) begin
      model_reset();
      return;
    end
    if (rv && q.size() == 0) begin
      m_unexp = 1; m_status = 0; model_capture(8'h00, rd);
    end else if (rv) begin
      h = q.pop_front();
      if (h != rd) begin
        if (m_err < 255) m_err++;
        m_status = 0;
        model_capture(h, rd);
      end
    end
    if (iv) begin
      if (q.size() < 4) q.push_back(~ia);
      else begin
        m_ovf = 1; m_status = 0; model_capture(8'h00, ia);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pending"}, 32'(pending), 32'(q.size()));
    chk({tag, ".issueReady"}, 32'(issueReady), 32'(q.size() < 4));
    chk({tag, ".status"}, 32'(status), 32'(m_status));
    chk({tag, ".errCount"}, 32'(errCount), 32'(m_err));
    chk({tag, ".errUnexpected"}, 32'(errUnexpected), 32'(m_unexp));
    chk({tag, ".errOverflow"}, 32'(errOverflow), 32'(m_ovf));
`ifdef SDRAM_READ_CHECKER_CAPTURE_EN
    chk({tag, ".firstErrValid"}, 32'(firstErrValid), 32'(m_fev));
    chk({tag, ".firstErrExpected"}, 32'(firstErrExpected), 32'(m_fexp));
    chk({tag, ".firstErrData"}, 32'(firstErrData), 32'(m_fdata));
`endif
  endtask

  // One clock: present inputs, advance the model, sample 1 time unit after the edge.
  task automatic step(input string tag, input bit iv, input logic [7:0] ia,
                      input bit rv, input logic [7:0] rd, input bit c);
    issueValid = iv; issueAddr = ia; rdValid = rv; rdData = rd; clr = c;
    model_step(iv, ia, rv, rd, c);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 8'h00, 0, 8'h00, 0);
  endtask

  initial begin
    logic [7:0] rnd_addr;
    logic [7:0] rnd_data;
    bit         iv;
    bit         rv;

    rst_ = 0; clr = 0; issueValid = 0; issueAddr = 0; rdValid = 0; rdData = 0;
    model_reset();
    #12;
    check_all("reset");
    rst_ = 1;
    @(posedge clk);
    #1;
    check_all("release");

    // In-order correct returns.
    step("seq0", 1, 8'h05, 0, 8'h00, 0);
    step("seq1", 1, 8'h10, 0, 8'h00, 0);
    step("seq2", 1, 8'h7F, 0, 8'h00, 0);
    step("seq3", 0, 8'h00, 1, 8'hFA, 0);
    step("seq4", 0, 8'h00, 1, 8'hEF, 0);
    step("seq5", 0, 8'h00, 1, 8'h80, 0);
    chk("seq.final_pending", 32'(pending), 32'd0);
    chk("seq.final_status", 32'(status), 32'd1);

    // Mismatch and counter saturation.
    step("mm_push", 1, 8'h22, 0, 8'h00, 0);
    step("mm_pop", 0, 8'h00, 1, 8'h00, 0);
    chk("mm.errCount_one", 32'(errCount), 32'd1);
    for (int i = 0; i < 300; i++) step("mm_sat", 1, 8'h22, 1, 8'h00, 0);
    chk("mm.errCount_sat", 32'(errCount), 32'hFF);
    step("clr0", 0, 8'h00, 0, 8'h00, 1);

    // Beat with nothing outstanding.
    step("unexp", 0, 8'h00, 1, 8'h3C, 0);
    chk("unexp.flag", 32'(errUnexpected), 32'd1);
`ifdef SDRAM_READ_CHECKER_CAPTURE_EN
    chk("unexp.firstErrData", 32'(firstErrData), 32'h3C);
`endif
    step("clr1", 0, 8'h00, 0, 8'h00, 1);

    // Push and beat together while empty: beat is unexpected, push lands.
    step("emptyboth", 1, 8'h41, 1, 8'hBE, 0);
    step("clr2", 0, 8'h00, 0, 8'h00, 1);

    // Overflow and full push+pop.
    for (int i = 0; i < 4; i++) step("fill", 1, 8'(8'h30 + i), 0, 8'h00, 0);
    step("ovf", 1, 8'h99, 0, 8'h00, 0);
    chk("ovf.pending", 32'(pending), 32'd4);
    step("clr3", 0, 8'h00, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) step("fill2", 1, 8'(8'h50 + i), 0, 8'h00, 0);
    step("fullpp", 1, 8'h60, 1, 8'hAF, 0);
    chk("fullpp.status", 32'(status), 32'd1);
    chk("fullpp.pending", 32'(pending), 32'd4);
    step("clr4", 0, 8'h00, 0, 8'h00, 1);

    // Random correct traffic across many pointer wraps.
    for (int i = 0; i < 1000; i++) begin
      iv = 1'($urandom_range(0, 1));
      rv = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (iv && q.size() == 4) rv = 1'b1;
      rnd_addr = 8'($urandom);
      rnd_data = rv ? q[0] : 8'($urandom);
      step("rand", iv, rnd_addr, rv, rnd_data, 0);
    end
    chk("rand.status", 32'(status), 32'd1);
    step("clr5", 0, 8'h00, 0, 8'h00, 1);

    // Mid-stream clr with errors set.
    for (int i = 0; i < 4; i++) step("mid", 1, 8'(8'h70 + i), 0, 8'h00, 0);
    step("mid_bad", 0, 8'h00, 1, 8'h00, 0);
    chk("mid.pending3", 32'(pending), 32'd3);
    step("mid_clr", 1, 8'h11, 1, 8'h00, 1);
    chk("mid_clr.pending", 32'(pending), 32'd0);

    // Mid-stream async reset, checked before any further edge.
    for (int i = 0; i < 4; i++) step("mid2", 1, 8'(8'h90 + i), 0, 8'h00, 0);
    step("mid2_bad", 0, 8'h00, 1, 8'h00, 0);
    issueValid = 0; rdValid = 0;
    #2;
    rst_ = 0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_ = 1;
    step("post_rst", 0, 8'h00, 1, 8'h6F, 0);
    chk("post_rst.unexp", 32'(errUnexpected), 32'd1);
    idle("tail");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
